// File: rtl/game_pkg.sv
// Shared definitions for the target game: widths and round FSM encoding.
package game_pkg;

    localparam int COORD_W = 5;
    localparam int SCORE_W = 8;
    localparam int TIMER_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PLAY,
        ST_RESOLVE,
        ST_OVER
    } state_t;

endpackage

// File: rtl/round_timer.sv
// Round countdown: load with a score-dependent reload value, decrement,
// and flag zero.
module round_timer
    import game_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [TIMER_W-1:0] TIMEOUT_STEP   = 24'd250_000,
    parameter logic [TIMER_W-1:0] MIN_TIMEOUT    = 24'd2_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [SCORE_W-1:0] i_score,
    output logic [TIMER_W-1:0] o_time_left,
    output logic               o_zero
);

    logic [TIMER_W-1:0] r_time;
    logic [31:0]        w_prod;
    logic [31:0]        w_base;
    logic [31:0]        w_min;
    logic [31:0]        w_diff;
    logic               w_under;
    logic               w_clamp;
    logic [TIMER_W-1:0] w_reload;

    // Upper diff bits feed the clamp compare, so truncation is safe.
    assign w_prod   = {24'd0, i_score} * {8'd0, TIMEOUT_STEP};
    assign w_base   = {8'd0, TIMEOUT_CYCLES};
    assign w_min    = {8'd0, MIN_TIMEOUT};
    assign w_under  = w_prod > w_base;
    assign w_diff   = w_base - w_prod;
    assign w_clamp  = w_under || (w_diff < w_min);
    assign w_reload = w_clamp ? MIN_TIMEOUT
                              : w_diff[TIMER_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_time <= '0;
        end else if (i_load) begin
            r_time <= w_reload;
        end else if (i_dec) begin
            r_time <= r_time - 1'b1;
        end
    end

    assign o_time_left = r_time;
    assign o_zero      = (r_time == '0);

endmodule

// File: rtl/round_ctrl.sv
// Round controller: shot/timeout resolution, score, lives and game over.
module round_ctrl
    import game_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd12_000_000,
    parameter logic [TIMER_W-1:0] TIMEOUT_STEP   = 24'd250_000,
    parameter logic [TIMER_W-1:0] MIN_TIMEOUT    = 24'd2_000_000,
    parameter logic [1:0]         LIVES          = 2'd3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               fire,
    input  logic [COORD_W-1:0] cursor_x,
    input  logic [COORD_W-1:0] cursor_y,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    output logic               result_valid,
    output logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic [TIMER_W-1:0] time_left,
    output logic               game_over
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_fire_q;
    logic               r_hit;
    logic [SCORE_W-1:0] r_score;
    logic [1:0]         r_lives;

    logic               w_hit_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [1:0]         w_lives_nxt;
    logic               w_load;
    logic               w_dec;
    logic               w_shot;
    logic               w_on_tgt;
    logic               w_zero;

    assign w_shot   = fire && !r_fire_q;
    assign w_on_tgt = (cursor_x == target_x)
                   && (cursor_y == target_y);

    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_score_nxt = '0;
                    w_lives_nxt = LIVES;
                    w_hit_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (w_shot) begin
                    w_hit_nxt   = w_on_tgt;
                    w_state_nxt = ST_RESOLVE;
                end else if (w_zero) begin
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = ST_RESOLVE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_RESOLVE: begin
                if (r_hit) begin
                    if (r_score != '1) begin
                        w_score_nxt = r_score + 1'b1;
                    end
                    w_load      = 1'b1;
                    w_state_nxt = ST_PLAY;
                end else if (r_lives == 2'd1) begin
                    w_lives_nxt = 2'd0;
                    w_state_nxt = ST_OVER;
                end else begin
                    w_lives_nxt = r_lives - 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_fire_q <= 1'b0;
            r_hit    <= 1'b0;
            r_score  <= '0;
            r_lives  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fire_q <= fire;
            r_hit    <= w_hit_nxt;
            r_score  <= w_score_nxt;
            r_lives  <= w_lives_nxt;
        end
    end

    // Reload uses the post-resolve score so a hit shortens the next round.
    round_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_STEP   (TIMEOUT_STEP),
        .MIN_TIMEOUT    (MIN_TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_dec       (w_dec),
        .i_score     (w_score_nxt),
        .o_time_left (time_left),
        .o_zero      (w_zero)
    );

    assign result_valid = (r_state == ST_LOAD)
                       || (r_state == ST_RESOLVE);
    assign game_over    = (r_state == ST_OVER);
    assign hit          = r_hit;
    assign score        = r_score;
    assign lives        = r_lives;

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a short timeout configuration.
module tb_round_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        fire = 1'b0;
    logic [4:0]  cursor_x = 5'd0;
    logic [4:0]  cursor_y = 5'd0;
    logic [4:0]  target_x = 5'd5;
    logic [4:0]  target_y = 5'd9;
    logic        result_valid;
    logic        hit;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [23:0] time_left;
    logic        game_over;

    int n_chk = 0;
    int n_err = 0;
    int rv_cnt = 0;
    int rv_mark;
    int n;

    round_ctrl #(
        .TIMEOUT_CYCLES (24'd16),
        .TIMEOUT_STEP   (24'd2),
        .MIN_TIMEOUT    (24'd4),
        .LIVES          (2'd3)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .fire         (fire),
        .cursor_x     (cursor_x),
        .cursor_y     (cursor_y),
        .target_x     (target_x),
        .target_y     (target_y),
        .result_valid (result_valid),
        .hit          (hit),
        .score        (score),
        .lives        (lives),
        .time_left    (time_left),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (result_valid) rv_cnt++;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(output int cnt);
        cnt = 0;
        while (!result_valid && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_hit();
        fire = 1'b1;
        tick();
        fire = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 0);
        chk("rst_time", 32'(time_left), 0);
        chk("rst_rv", 32'(result_valid), 0);
        reset_n = 1'b1;
        tick();

        // start a game
        rv_mark = rv_cnt;
        start = 1'b1;
        tick();
        chk("load_rv", 32'(result_valid), 1);
        chk("load_lives", 32'(lives), 3);
        start = 1'b0;
        tick();
        chk("play_time", 32'(time_left), 16);
        chk("play_rv", 32'(result_valid), 0);
        chk("start_pulses", 32'(rv_cnt - rv_mark), 1);

        // hit, with fire held through RESOLVE
        cursor_x = 5'd5;
        cursor_y = 5'd9;
        fire = 1'b1;
        tick();
        chk("hit_flag", 32'(hit), 1);
        chk("hit_rv", 32'(result_valid), 1);
        tick();
        chk("hit_score", 32'(score), 1);
        chk("hit_reload", 32'(time_left), 14);
        rv_mark = rv_cnt;
        tick();
        tick();
        tick();
        chk("held_time", 32'(time_left), 11);
        chk("held_noshot", 32'(rv_cnt - rv_mark), 0);
        fire = 1'b0;

        // three timeouts end the game
        cursor_x = 5'd0;
        wait_rv(n);
        chk("to1_hit", 32'(hit), 0);
        tick();
        chk("to1_lives", 32'(lives), 2);
        chk("to1_time", 32'(time_left), 14);
        rv_mark = rv_cnt;
        wait_rv(n);
        chk("to2_len", 32'(n), 15);
        tick();
        chk("to2_lives", 32'(lives), 1);
        chk("to2_pulses", 32'(rv_cnt - rv_mark), 1);
        wait_rv(n);
        chk("to3_len", 32'(n), 15);
        tick();
        chk("over_lives", 32'(lives), 0);
        chk("over_flag", 32'(game_over), 1);

        rv_mark = rv_cnt;
        for (int i = 0; i < 3; i++) begin
            do_hit();
        end
        chk("over_norv", 32'(rv_cnt - rv_mark), 0);
        chk("over_hold", 32'(game_over), 1);

        // restart and full-length timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("rs_lives", 32'(lives), 3);
        chk("rs_score", 32'(score), 0);
        chk("rs_time", 32'(time_left), 16);
        wait_rv(n);
        chk("to_len17", 32'(n), 17);
        chk("to_hit", 32'(hit), 0);
        tick();
        chk("to_lives", 32'(lives), 2);

        // shot on the zero cycle
        cursor_x = 5'd5;
        n = 0;
        while (time_left != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("zero_reach", 32'(time_left), 0);
        fire = 1'b1;
        tick();
        chk("zero_hit", 32'(hit), 1);
        chk("zero_rv", 32'(result_valid), 1);
        fire = 1'b0;
        tick();
        chk("zero_score", 32'(score), 1);
        chk("zero_lives", 32'(lives), 2);

        // reload shrink and clamp
        for (int i = 0; i < 4; i++) do_hit();
        chk("s5_time", 32'(time_left), 6);
        do_hit();
        do_hit();
        chk("s7_score", 32'(score), 7);
        chk("s7_clamp", 32'(time_left), 4);

        // saturation
        for (int i = 0; i < 260; i++) do_hit();
        chk("sat_score", 32'(score), 255);
        chk("sat_time", 32'(time_left), 4);
        chk("sat_lives", 32'(lives), 2);

        // async reset mid-round
        tick();
        reset_n = 1'b0;
        #1;
        chk("ar_score", 32'(score), 0);
        chk("ar_lives", 32'(lives), 0);
        chk("ar_time", 32'(time_left), 0);
        chk("ar_rv", 32'(result_valid), 0);
        chk("ar_over", 32'(game_over), 0);
        tick();
        chk("ar_idle_rv", 32'(result_valid), 0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
